// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 access-size codes
// and the encoding of the transaction state machine.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper: store lane replication and byte strobes,
// load byte/halfword extraction with sign or zero extension, and the
// misaligned/illegal request check.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic        i_isWrite,
  input  logic [31:0] i_storeData,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_loadData,
  output logic        o_fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

  // Replicate store data across every lane it could land in and enable only the addressed bytes.
  always_comb begin
    o_wdata = 32'h0;
    o_wstrb = 4'b0000;
    case (i_funct3)
      LSU_B: begin
        o_wdata = {4{i_storeData[7:0]}};
        o_wstrb = 4'b0001 << i_off;
      end
      LSU_H: begin
        o_wdata = {2{i_storeData[15:0]}};
        o_wstrb = 4'b0011 << i_off;
      end
      LSU_W: begin
        o_wdata = i_storeData;
        o_wstrb = 4'b1111;
      end
      default: begin
        o_wdata = 32'h0;
        o_wstrb = 4'b0000;
      end
    endcase
  end

  // Pick the addressed byte or halfword out of the read word and extend it to 32 bits.
  always_comb begin
    o_loadData = 32'h0;
    case (i_funct3)
      LSU_B:   o_loadData = {{24{w_byte[7]}}, w_byte};
      LSU_BU:  o_loadData = {24'h0, w_byte};
      LSU_H:   o_loadData = {{16{w_half[15]}}, w_half};
      LSU_HU:  o_loadData = {16'h0, w_half};
      LSU_W:   o_loadData = i_rdata;
      default: o_loadData = 32'h0;
    endcase
  end

  // Reject unknown sizes, unsigned sizes on stores, and accesses not aligned to their size.
  always_comb begin
    o_fault = 1'b1;
    case (i_funct3)
      LSU_B:   o_fault = 1'b0;
      LSU_H:   o_fault = i_off[0];
      LSU_W:   o_fault = (i_off != 2'b00);
      LSU_BU:  o_fault = i_isWrite;
      LSU_HU:  o_fault = i_isWrite | i_off[0];
      default: o_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load or store from the pipeline, runs it
// over a req/ack data bus with a watchdog, and reports completion with a
// single lsuDone pulse carrying the load result and any fault flag.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsuValid,
  input  logic        lsuRead,
  input  logic        lsuWrite,
  input  logic [2:0]  lsuFunct3,
  input  logic [31:0] lsuAddr,
  input  logic [31:0] lsuStoreData,
  output logic        lsuReady,
  output logic        lsuDone,
  output logic [31:0] lsuLoadData,
  output logic        lsuMisaligned,
  output logic        lsuBusErr,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memWstrb,
  input  logic        memAck,
  input  logic [31:0] memRdata
);

  localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  lsu_state_e r_state;
  lsu_state_e w_nextState;

  logic [31:0]          r_addr;
  logic [2:0]           r_funct3;
  logic                 r_we;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [31:0]          r_loadData;
  logic                 r_misaligned;
  logic                 r_busErr;

  logic                 w_idle;
  logic                 w_accept;
  logic                 w_fault;
  logic                 w_timeout;
  logic [2:0]           w_alignFunct3;
  logic [1:0]           w_alignOff;
  logic [31:0]          w_wdata;
  logic [3:0]           w_wstrb;
  logic [31:0]          w_loadData;
  logic                 w_alignFault;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle & lsuValid & (lsuRead | lsuWrite);
  assign w_fault   = (lsuRead & lsuWrite) | w_alignFault;
  assign w_timeout = (r_cnt == LP_LAST);

  // The aligner sees the incoming request while idle and the latched one while waiting for data.
  assign w_alignFunct3 = w_idle ? lsuFunct3    : r_funct3;
  assign w_alignOff    = w_idle ? lsuAddr[1:0] : r_addr[1:0];

  lsu_align u_align (
    .i_funct3    (w_alignFunct3),
    .i_off       (w_alignOff),
    .i_isWrite   (lsuWrite),
    .i_storeData (lsuStoreData),
    .i_rdata     (memRdata),
    .o_wdata     (w_wdata),
    .o_wstrb     (w_wstrb),
    .o_loadData  (w_loadData),
    .o_fault     (w_alignFault)
  );

  assign lsuReady      = w_idle;
  assign lsuDone       = (r_state == S_RESP);
  assign lsuLoadData   = lsuDone ? r_loadData : 32'h0;
  assign lsuMisaligned = lsuDone & r_misaligned;
  assign lsuBusErr     = lsuDone & r_busErr;
  assign memReq        = (r_state == S_REQ);
  assign memWe         = memReq & r_we;
  assign memAddr       = {r_addr[31:2], 2'b00};
  assign memWdata      = r_wdata;
  assign memWstrb      = r_wstrb;

  // State register; reset abandons any bus access in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Faults skip the bus entirely; an ack in the last watchdog cycle still counts as success.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_nextState = w_fault ? S_RESP : S_REQ;
      end
      S_REQ: begin
        if (memAck || w_timeout) w_nextState = S_RESP;
      end
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Request latching, watchdog counting and capture of the completion result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= 32'h0;
      r_funct3     <= 3'b000;
      r_we         <= 1'b0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'b0000;
      r_cnt        <= '0;
      r_loadData   <= 32'h0;
      r_misaligned <= 1'b0;
      r_busErr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr       <= lsuAddr;
            r_funct3     <= lsuFunct3;
            r_we         <= lsuWrite & ~w_fault;
            r_wdata      <= (lsuWrite & ~w_fault) ? w_wdata : 32'h0;
            r_wstrb      <= (lsuWrite & ~w_fault) ? w_wstrb : 4'b0000;
            r_cnt        <= '0;
            r_loadData   <= 32'h0;
            r_misaligned <= w_fault;
            r_busErr     <= 1'b0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
          if (memAck) begin
            r_loadData <= r_we ? 32'h0 : w_loadData;
          end else if (w_timeout) begin
            r_busErr <= 1'b1;
          end
        end
        S_RESP: begin
          r_cnt        <= '0;
          r_misaligned <= 1'b0;
          r_busErr     <= 1'b0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by random
// accesses, all checked against a spec-level reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsuValid;
  logic        lsuRead;
  logic        lsuWrite;
  logic [2:0]  lsuFunct3;
  logic [31:0] lsuAddr;
  logic [31:0] lsuStoreData;
  logic        lsuReady;
  logic        lsuDone;
  logic [31:0] lsuLoadData;
  logic        lsuMisaligned;
  logic        lsuBusErr;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;
  logic        memAck;
  logic [31:0] memRdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] lastLoad;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_WIDTH(9)) dut (
    .clk           (clk),
    .rst           (rst),
    .lsuValid      (lsuValid),
    .lsuRead       (lsuRead),
    .lsuWrite      (lsuWrite),
    .lsuFunct3     (lsuFunct3),
    .lsuAddr       (lsuAddr),
    .lsuStoreData  (lsuStoreData),
    .lsuReady      (lsuReady),
    .lsuDone       (lsuDone),
    .lsuLoadData   (lsuLoadData),
    .lsuMisaligned (lsuMisaligned),
    .lsuBusErr     (lsuBusErr),
    .memReq        (memReq),
    .memWe         (memWe),
    .memAddr       (memAddr),
    .memWdata      (memWdata),
    .memWstrb      (memWstrb),
    .memAck        (memAck),
    .memRdata      (memRdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model: is the request rejected without a bus access?
  function automatic bit modelFault(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
    if (rd && wr) return 1'b1;
    case (f3)
      3'd0:    return 1'b0;
      3'd1:    return (a % 2) != 0;
      3'd2:    return (a % 4) != 0;
      3'd4:    return wr;
      3'd5:    return wr || ((a % 2) != 0);
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: extended load value from the read word
  function automatic logic [31:0] modelLoad(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    b = (rdata >> (8 * (a % 4))) & 32'hFF;
    h = (rdata >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return rdata;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: store data as it appears on the bus
  function automatic logic [31:0] modelWdata(logic [2:0] f3, logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Reference model: byte strobes for a store
  function automatic logic [3:0] modelStrb(logic [2:0] f3, logic [31:0] a);
    int unsigned off;
    off = a % 4;
    case (f3)
      3'd0:    return 4'(1 << off);
      3'd1:    return 4'(3 << off);
      default: return 4'hF;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete access; ackDelay >= TIMEOUT means the bus never answers.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int ackDelay, input logic [31:0] rdata);
    bit  expFault;
    bit  timedOut;
    int  reqCycles;
    int  expCycles;
    checkOutput("readyBeforeAccept", {31'b0, lsuReady}, 32'd1);
    lsuValid = 1'b1; lsuRead = rd; lsuWrite = wr;
    lsuFunct3 = f3; lsuAddr = addr; lsuStoreData = data;
    step();
    lsuValid = 1'b0; lsuRead = 1'b0; lsuWrite = 1'b0;
    lsuAddr = $urandom; lsuStoreData = $urandom; lsuFunct3 = 3'($urandom);
    expFault = modelFault(rd, wr, f3, addr);
    if (expFault) begin
      checkOutput("faultNoReq",    {31'b0, memReq},        32'd0);
      checkOutput("faultDone",     {31'b0, lsuDone},       32'd1);
      checkOutput("faultFlag",     {31'b0, lsuMisaligned}, 32'd1);
      checkOutput("faultNoBusErr", {31'b0, lsuBusErr},     32'd0);
      step();
      checkOutput("faultDoneOnce", {31'b0, lsuDone},       32'd0);
      checkOutput("faultReadyBack",{31'b0, lsuReady},      32'd1);
    end else begin
      checkOutput("reqAddr", memAddr, addr & 32'hFFFF_FFFC);
      checkOutput("reqWe",   {31'b0, memWe}, {31'b0, wr});
      checkOutput("reqStrb", {28'b0, memWstrb}, wr ? {28'b0, modelStrb(f3, addr)} : 32'd0);
      if (wr) checkOutput("reqWdata", memWdata, modelWdata(f3, data));
      reqCycles = 0;
      while (memReq === 1'b1 && reqCycles < TIMEOUT + 4) begin
        reqCycles++;
        if (reqCycles - 1 == ackDelay) begin
          memAck = 1'b1; memRdata = rdata;
        end else begin
          memRdata = $urandom;
        end
        step();
        memAck = 1'b0;
      end
      timedOut  = (ackDelay >= TIMEOUT);
      expCycles = timedOut ? TIMEOUT : ackDelay + 1;
      checkOutput("reqCycles", 32'(reqCycles), 32'(expCycles));
      checkOutput("done",      {31'b0, lsuDone},       32'd1);
      checkOutput("busErr",    {31'b0, lsuBusErr},     {31'b0, timedOut});
      checkOutput("noMisalign",{31'b0, lsuMisaligned}, 32'd0);
      checkOutput("loadData",  lsuLoadData, (rd && !timedOut) ? modelLoad(f3, addr, rdata) : 32'h0);
      lastLoad = lsuLoadData;
      step();
      checkOutput("doneOnce",  {31'b0, lsuDone},  32'd0);
      checkOutput("readyBack", {31'b0, lsuReady}, 32'd1);
    end
  endtask

  initial begin
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    rst = 1'b1; lsuValid = 1'b0; lsuRead = 1'b0; lsuWrite = 1'b0;
    lsuFunct3 = 3'b000; lsuAddr = 32'h0; lsuStoreData = 32'h0;
    memAck = 1'b0; memRdata = 32'h0;
    step();
    step();
    checkOutput("rstReady",    {31'b0, lsuReady},      32'd1);
    checkOutput("rstDone",     {31'b0, lsuDone},       32'd0);
    checkOutput("rstReq",      {31'b0, memReq},        32'd0);
    checkOutput("rstWe",       {31'b0, memWe},         32'd0);
    checkOutput("rstStrb",     {28'b0, memWstrb},      32'd0);
    checkOutput("rstAddr",     memAddr,                32'd0);
    checkOutput("rstWdata",    memWdata,               32'd0);
    checkOutput("rstLoad",     lsuLoadData,            32'd0);
    checkOutput("rstMisalign", {31'b0, lsuMisaligned}, 32'd0);
    checkOutput("rstBusErr",   {31'b0, lsuBusErr},     32'd0);
    rst = 1'b0;
    step();

    $display("[TB] directed loads and stores");
    applyStimulus(1, 0, 3'd0, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
    checkOutput("lbValue", lastLoad, 32'hFFFF_FF80);
    applyStimulus(1, 0, 3'd5, 32'h0000_2002, 32'h0, 0, 32'h8001_0000);
    checkOutput("lhuValue", lastLoad, 32'h0000_8001);
    applyStimulus(1, 0, 3'd1, 32'h0000_2002, 32'h0, 1, 32'h8001_0000);
    checkOutput("lhValue", lastLoad, 32'hFFFF_8001);
    applyStimulus(0, 1, 3'd0, 32'h0000_3001, 32'h1234_56AB, 0, 32'h0);
    applyStimulus(0, 1, 3'd2, 32'h0000_3004, 32'hDEAD_BEEF, 2, 32'h0);

    $display("[TB] faults");
    applyStimulus(1, 0, 3'd2, 32'h0000_4002, 32'h0, 0, 32'h0);
    applyStimulus(1, 1, 3'd2, 32'h0000_4000, 32'h0, 0, 32'h0);
    applyStimulus(0, 1, 3'd4, 32'h0000_4000, 32'h0, 0, 32'h0);
    applyStimulus(1, 0, 3'd7, 32'h0000_4000, 32'h0, 0, 32'h0);

    $display("[TB] no-op request and stray ack");
    lsuValid = 1'b1; lsuRead = 1'b0; lsuWrite = 1'b0;
    memAck = 1'b1;
    step();
    lsuValid = 1'b0; memAck = 1'b0;
    checkOutput("noopReady", {31'b0, lsuReady}, 32'd1);
    checkOutput("noopReq",   {31'b0, memReq},   32'd0);
    checkOutput("noopDone",  {31'b0, lsuDone},  32'd0);

    $display("[TB] watchdog");
    applyStimulus(1, 0, 3'd2, 32'h0000_5000, 32'h0, 1000, 32'h0);
    applyStimulus(1, 0, 3'd2, 32'h0000_5004, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
    checkOutput("lastCycleAck", lastLoad, 32'hCAFE_F00D);

    $display("[TB] reset during request");
    lsuValid = 1'b1; lsuRead = 1'b1; lsuFunct3 = 3'd2; lsuAddr = 32'h0000_6000;
    step();
    lsuValid = 1'b0; lsuRead = 1'b0;
    step();
    step();
    checkOutput("midReq", {31'b0, memReq}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstMidReq",   {31'b0, memReq},   32'd0);
    checkOutput("rstMidReady", {31'b0, lsuReady}, 32'd1);
    checkOutput("rstMidDone",  {31'b0, lsuDone},  32'd0);
    step();
    checkOutput("rstMidNoDone", {31'b0, lsuDone}, 32'd0);
    applyStimulus(1, 0, 3'd2, 32'h0000_6008, 32'h0, 0, 32'h1357_9BDF);

    $display("[TB] random accesses");
    for (int i = 0; i < 60; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      if ($urandom_range(0, 7) == 0) begin rd = 1'b1; wr = 1'b1; end
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      applyStimulus(rd, wr, f3, a, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
